// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC alarm controller: FSM states, register
// indices, control/status bit positions and the BCD MM:SS validity check.
package rtc_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_FIRED    = 2'd2
  } alarm_state_t;

  // Register index, taken from address bits [3:2]
  localparam logic [1:0] RTC_REG_CTRL   = 2'd0;
  localparam logic [1:0] RTC_REG_ALARM  = 2'd1;
  localparam logic [1:0] RTC_REG_STATUS = 2'd2;
  localparam logic [1:0] RTC_REG_PERIOD = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_REPEAT = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS bit positions (state occupies [5:4])
  localparam int STAT_FIRED    = 0;
  localparam int STAT_PERIODIC = 1;
  localparam int STAT_BCD_ERR  = 2;

  // Largest legal periodic interval in seconds
  localparam logic [5:0] PERIOD_MAX = 6'd59;

  // True when {minHi, minLo, secHi, secLo} is a legal MM:SS value
  function automatic logic bcd_mmss_valid(input logic [15:0] v);
    return (v[15:12] <= 4'd5) && (v[11:8] <= 4'd9) &&
           (v[7:4]   <= 4'd5) && (v[3:0]  <= 4'd9);
  endfunction

endpackage

// File: rtl/rtc_period_timer.sv
// Periodic-tick down-counter: counts RTC second ticks and emits a one-cycle
// pulse each time the programmed interval elapses. A zero period is idle.
module rtc_period_timer (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       load_in,
  input  logic [5:0] load_value_in,
  input  logic [5:0] period_in,
  output logic       pulse_out
);

  logic [5:0] cnt_q, cnt_d;

  // Reload on a PERIOD write; otherwise count ticks down and wrap to period
  always_comb begin
    cnt_d     = cnt_q;
    pulse_out = 1'b0;
    if (load_in) begin
      cnt_d = load_value_in;
    end else if (tick_in && (period_in != 6'd0)) begin
      if (cnt_q <= 6'd1) begin
        pulse_out = 1'b1;
        cnt_d     = period_in;
      end else begin
        cnt_d = cnt_q - 6'd1;
      end
    end
  end

  // Counter register
  always_ff @(posedge clk_in) begin
    if (reset) cnt_q <= 6'd0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rtc_alarm_ctrl.sv
// Memory-mapped alarm controller for the RTC MM:SS time value.
// Optional periodic tick timer is built in when RTC_ALARM_PERIODIC_EN is
// defined; otherwise register index 3 reads 0 and PERIODIC stays 0.
module rtc_alarm_ctrl
  import rtc_pkg::*;
(
  input  logic        clk_in,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out,
  input  logic [15:0] time_in,
  output logic        irq_out
);

  logic [2:0]   ctrl_q, ctrl_d;
  logic [15:0]  alarm_q, alarm_d;
  logic [15:0]  time_prev_q, time_prev_d;
  logic         fired_q, fired_d;
  logic         periodic_q, periodic_d;
  logic         bcd_err_q, bcd_err_d;
  alarm_state_t state_q, state_d;

  logic [1:0]  reg_idx;
  logic        bus_wr, wr_ctrl, wr_alarm, wr_status;
  logic [15:0] alarm_merged;
  logic        alarm_ok, tick, match, periodic_pulse;
  logic        w1c_fired, w1c_periodic, w1c_bcd;
  logic [31:0] period_rd;

  // Bus inputs that the register map never looks at
  logic unused_bus;
  assign unused_bus = ^{read_in, address_in[31:4], address_in[1:0], write_value_in[31:16]};

  assign reg_idx   = address_in[3:2];
  assign bus_wr    = sel_in && (write_mask_in != 4'd0);
  assign wr_ctrl   = bus_wr && (reg_idx == RTC_REG_CTRL)   && write_mask_in[0];
  assign wr_alarm  = bus_wr && (reg_idx == RTC_REG_ALARM)  && (write_mask_in[1:0] != 2'd0);
  assign wr_status = bus_wr && (reg_idx == RTC_REG_STATUS) && write_mask_in[0];

  assign w1c_fired    = wr_status && write_value_in[STAT_FIRED];
  assign w1c_periodic = wr_status && write_value_in[STAT_PERIODIC];
  assign w1c_bcd      = wr_status && write_value_in[STAT_BCD_ERR];

  assign alarm_merged = {write_mask_in[1] ? write_value_in[15:8] : alarm_q[15:8],
                         write_mask_in[0] ? write_value_in[7:0]  : alarm_q[7:0]};
  assign alarm_ok     = bcd_mmss_valid(alarm_merged);

  // A second boundary is any change of the RTC value; compare against the
  // currently stored alarm so a same-cycle ALARM write cannot affect it.
  assign tick  = (time_in != time_prev_q);
  assign match = tick && (time_in == alarm_q);

`ifdef RTC_ALARM_PERIODIC_EN
  logic [5:0] period_q, period_d;
  logic       wr_period;
  logic [5:0] period_clamped;

  assign wr_period      = bus_wr && (reg_idx == RTC_REG_PERIOD) && write_mask_in[0];
  assign period_clamped = (write_value_in[7:0] > 8'd59) ? PERIOD_MAX : write_value_in[5:0];
  assign period_d       = wr_period ? period_clamped : period_q;
  assign period_rd      = {26'd0, period_q};

  // Interval register
  always_ff @(posedge clk_in) begin
    if (reset) period_q <= 6'd0;
    else       period_q <= period_d;
  end

  rtc_period_timer u_period_timer (
    .clk_in        (clk_in),
    .reset         (reset),
    .tick_in       (tick),
    .load_in       (wr_period),
    .load_value_in (period_clamped),
    .period_in     (period_q),
    .pulse_out     (periodic_pulse)
  );
`else
  assign periodic_pulse = 1'b0;
  assign period_rd      = 32'd0;
`endif

  // Register updates and alarm FSM next-state
  always_comb begin
    ctrl_d      = ctrl_q;
    alarm_d     = alarm_q;
    time_prev_d = time_in;
    fired_d     = fired_q & ~w1c_fired;
    periodic_d  = (periodic_q & ~w1c_periodic) | periodic_pulse;
    bcd_err_d   = (bcd_err_q & ~w1c_bcd) | (wr_alarm & ~alarm_ok);
    state_d     = state_q;

    if (wr_alarm && alarm_ok) alarm_d = alarm_merged;
    if (wr_ctrl)              ctrl_d  = write_value_in[2:0];

    case (state_q)
      ST_DISABLED: begin
        if (wr_ctrl && write_value_in[CTRL_EN]) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (match) begin
          state_d = ST_FIRED;
          fired_d = 1'b1;
        end
      end
      ST_FIRED: begin
        // A fresh match outranks the acknowledge
        if (match) begin
          fired_d = 1'b1;
        end else if (w1c_fired) begin
          if (ctrl_q[CTRL_REPEAT]) begin
            state_d = ST_ARMED;
          end else begin
            state_d         = ST_DISABLED;
            ctrl_d[CTRL_EN] = 1'b0;
          end
        end
      end
      default: state_d = ST_DISABLED;
    endcase

    // Disabling outranks everything, including a coincident match
    if (wr_ctrl && !write_value_in[CTRL_EN]) begin
      state_d = ST_DISABLED;
      fired_d = fired_q & ~w1c_fired;
    end
  end

  // State and register flops
  always_ff @(posedge clk_in) begin
    if (reset) begin
      ctrl_q      <= 3'd0;
      alarm_q     <= 16'd0;
      time_prev_q <= 16'd0;
      fired_q     <= 1'b0;
      periodic_q  <= 1'b0;
      bcd_err_q   <= 1'b0;
      state_q     <= ST_DISABLED;
    end else begin
      ctrl_q      <= ctrl_d;
      alarm_q     <= alarm_d;
      time_prev_q <= time_prev_d;
      fired_q     <= fired_d;
      periodic_q  <= periodic_d;
      bcd_err_q   <= bcd_err_d;
      state_q     <= state_d;
    end
  end

  // Zero-wait-state combinational read mux
  always_comb begin
    read_value_out = 32'd0;
    if (sel_in) begin
      case (reg_idx)
        RTC_REG_CTRL:   read_value_out = {29'd0, ctrl_q};
        RTC_REG_ALARM:  read_value_out = {16'd0, alarm_q};
        RTC_REG_STATUS: read_value_out = {26'd0, state_q, 1'b0, bcd_err_q, periodic_q, fired_q};
        default:        read_value_out = period_rd;
      endcase
    end
  end

  assign ready_out = sel_in;
  assign irq_out   = ctrl_q[CTRL_IRQ_EN] & (fired_q | periodic_q);

endmodule

// File: tb/tb_rtc_alarm_ctrl.sv
// Directed self-checking bench for rtc_alarm_ctrl.
module tb_rtc_alarm_ctrl;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;
  logic [15:0] time_in;
  logic        irq_out;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] I_CTRL = 2'd0, I_ALARM = 2'd1, I_STATUS = 2'd2, I_PERIOD = 2'd3;

  rtc_alarm_ctrl dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .address_in     (address_in),
    .sel_in         (sel_in),
    .read_in        (read_in),
    .read_value_out (read_value_out),
    .write_mask_in  (write_mask_in),
    .write_value_in (write_value_in),
    .ready_out      (ready_out),
    .time_in        (time_in),
    .irq_out        (irq_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr_tm(input logic [1:0] idx, input logic [3:0] m, input logic [31:0] d,
                       input logic [15:0] t);
    @(negedge clk_in);
    sel_in = 1'b1; address_in = {28'd0, idx, 2'b00}; write_mask_in = m; write_value_in = d;
    time_in = t;
    @(negedge clk_in);
    sel_in = 1'b0; write_mask_in = 4'd0; write_value_in = 32'd0;
    $display("write idx=%0d mask=%b data=%h time=%h", idx, m, d, t);
  endtask

  task automatic wr(input logic [1:0] idx, input logic [3:0] m, input logic [31:0] d);
    wr_tm(idx, m, d, time_in);
  endtask

  task automatic set_time(input logic [15:0] t);
    @(negedge clk_in);
    time_in = t;
    @(negedge clk_in);
    $display("time -> %h", t);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] idx, input logic [31:0] exp);
    @(negedge clk_in);
    sel_in = 1'b1; read_in = 1'b1; address_in = {28'd0, idx, 2'b00};
    #1;
    check(tag, read_value_out, exp);
    check({tag, "_ready"}, {31'd0, ready_out}, 32'd1);
    $display("read idx=%0d data=%h expect=%h", idx, read_value_out, exp);
    sel_in = 1'b0; read_in = 1'b0;
  endtask

  task automatic irq_chk(input string tag, input logic exp);
    check(tag, {31'd0, irq_out}, {31'd0, exp});
    $display("irq=%b expect=%b", irq_out, exp);
  endtask

  initial begin
    reset = 1'b1; sel_in = 1'b0; read_in = 1'b0; address_in = 32'd0;
    write_mask_in = 4'd0; write_value_in = 32'd0; time_in = 16'd0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    reset = 1'b0;

    // Reset state
    rd_chk("rst_ctrl", I_CTRL, 32'h0);
    rd_chk("rst_alarm", I_ALARM, 32'h0);
    rd_chk("rst_status", I_STATUS, 32'h0);
    rd_chk("rst_period", I_PERIOD, 32'h0);
    irq_chk("rst_irq", 1'b0);

    // Arm with REPEAT and fire on 0x0102
    wr(I_ALARM, 4'b0011, 32'h0000_0102);
    wr(I_CTRL, 4'b0001, 32'h7);
    rd_chk("armed", I_STATUS, 32'h10);
    set_time(16'h0101);
    irq_chk("no_fire_0101", 1'b0);
    set_time(16'h0102);
    irq_chk("fire_irq", 1'b1);
    rd_chk("fire_status", I_STATUS, 32'h21);
    #1;
    check("idle_read_zero", read_value_out, 32'h0);
    check("idle_ready", {31'd0, ready_out}, 32'h0);

    // Acknowledge with REPEAT, hold time: no re-fire
    wr(I_STATUS, 4'b0001, 32'h1);
    rd_chk("rearm", I_STATUS, 32'h10);
    repeat (8) @(negedge clk_in);
    rd_chk("hold_no_refire", I_STATUS, 32'h10);
    irq_chk("hold_irq", 1'b0);
    set_time(16'h0103);
    set_time(16'h0102);
    rd_chk("refire", I_STATUS, 32'h21);

    // REPEAT=0 acknowledge disables and clears EN
    wr(I_CTRL, 4'b0001, 32'h5);
    rd_chk("fired_ctrl_write", I_STATUS, 32'h21);
    wr(I_STATUS, 4'b0001, 32'h1);
    rd_chk("oneshot_status", I_STATUS, 32'h00);
    rd_chk("oneshot_ctrl", I_CTRL, 32'h4);
    irq_chk("oneshot_irq", 1'b0);

    // BCD validation and byte-lane masking
    wr(I_ALARM, 4'b0011, 32'h0000_6A00);
    rd_chk("bad_alarm_kept", I_ALARM, 32'h0102);
    rd_chk("bcd_err_set", I_STATUS, 32'h04);
    wr(I_STATUS, 4'b0001, 32'h4);
    rd_chk("bcd_err_clr", I_STATUS, 32'h00);
    wr(I_ALARM, 4'b0001, 32'h0000_0059);
    rd_chk("lane0_write", I_ALARM, 32'h0159);
    wr(I_ALARM, 4'b0001, 32'h0000_0060);
    rd_chk("bad_sechi_kept", I_ALARM, 32'h0159);
    rd_chk("bad_sechi_err", I_STATUS, 32'h04);
    wr(I_ALARM, 4'b0010, 32'h0000_0700);
    rd_chk("lane1_write", I_ALARM, 32'h0759);
    wr(I_ALARM, 4'b1100, 32'hFFFF_FFFF);
    rd_chk("upper_lanes_ignored", I_ALARM, 32'h0759);
    wr(I_STATUS, 4'b0001, 32'h4);

    // Match and W1C in the same cycle: match wins
    wr(I_CTRL, 4'b0001, 32'h7);
    set_time(16'h0759);
    rd_chk("fire_0759", I_STATUS, 32'h21);
    set_time(16'h0758);
    wr_tm(I_STATUS, 4'b0001, 32'h1, 16'h0759);
    rd_chk("match_beats_w1c", I_STATUS, 32'h21);
    wr(I_STATUS, 4'b0001, 32'h1);
    rd_chk("ack_after", I_STATUS, 32'h10);

    // Disable and match in the same cycle: disable wins
    set_time(16'h0800);
    wr_tm(I_CTRL, 4'b0001, 32'h4, 16'h0759);
    rd_chk("disable_beats_match", I_STATUS, 32'h00);
    irq_chk("disable_irq", 1'b0);

`ifdef RTC_ALARM_PERIODIC_EN
    wr(I_PERIOD, 4'b0001, 32'h3);
    rd_chk("period_rd", I_PERIOD, 32'h3);
    set_time(16'h1000);
    set_time(16'h1001);
    rd_chk("per_tick2", I_STATUS, 32'h00);
    set_time(16'h1002);
    rd_chk("per_tick3", I_STATUS, 32'h02);
    irq_chk("per_irq3", 1'b1);
    wr(I_STATUS, 4'b0001, 32'h2);
    irq_chk("per_ack_irq", 1'b0);
    set_time(16'h1003);
    set_time(16'h1004);
    rd_chk("per_tick5", I_STATUS, 32'h00);
    set_time(16'h1005);
    rd_chk("per_tick6", I_STATUS, 32'h02);
    wr(I_STATUS, 4'b0001, 32'h2);
    wr(I_PERIOD, 4'b0001, 32'h46);
    rd_chk("period_clamp", I_PERIOD, 32'h3B);
    wr(I_PERIOD, 4'b0001, 32'h0);
`else
    wr(I_PERIOD, 4'b1111, 32'hFFFF_FFFF);
    rd_chk("period_absent", I_PERIOD, 32'h0);
    set_time(16'h1000);
    set_time(16'h1001);
    set_time(16'h1002);
    rd_chk("periodic_absent", I_STATUS, 32'h00);
`endif

    // Reset while fired with interrupt pending
    wr(I_CTRL, 4'b0001, 32'h5);
    set_time(16'h0758);
    set_time(16'h0759);
    irq_chk("pre_reset_irq", 1'b1);
    @(negedge clk_in);
    reset = 1'b1;
    @(posedge clk_in);
    #1;
    irq_chk("reset_irq", 1'b0);
    rd_chk("reset_ctrl", I_CTRL, 32'h0);
    rd_chk("reset_alarm", I_ALARM, 32'h0);
    rd_chk("reset_status", I_STATUS, 32'h0);
    rd_chk("reset_period", I_PERIOD, 32'h0);
    @(negedge clk_in);
    reset = 1'b0;
    repeat (2) @(negedge clk_in);
    rd_chk("post_reset_status", I_STATUS, 32'h0);
    irq_chk("post_reset_irq", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
